// File: rtl/vga_text_pkg.sv
// Shared constants, scancode values and FSM states for the VGA text writer.
// KBD_SHIFT_EN (when defined) enables shift tracking in the writer and lookup.
package vga_text_pkg;

  localparam int COLS       = 70;
  localparam int ROWS       = 30;
  localparam int VMEM_DEPTH = 2240;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef enum logic [1:0] {
    INIT,
    IDLE,
    CLEAR
  } state_t;

endpackage

// File: rtl/scancode_to_ascii.sv
// Combinational PS/2 set-2 make code to ASCII lookup for letters, digits and space.
// Shifted mapping (upper case, US digit symbols) only exists when KBD_SHIFT_EN is defined.
module scancode_to_ascii (
  input  logic [7:0] scancode,
  input  logic       shift,
  output logic [7:0] ascii,
  output logic       printable
);

  logic [7:0] lower;

  always_comb begin
    lower     = 8'h00;
    printable = 1'b1;
    case (scancode)
      8'h1C: lower = 8'h61; 8'h32: lower = 8'h62; 8'h21: lower = 8'h63; 8'h23: lower = 8'h64;
      8'h24: lower = 8'h65; 8'h2B: lower = 8'h66; 8'h34: lower = 8'h67; 8'h33: lower = 8'h68;
      8'h43: lower = 8'h69; 8'h3B: lower = 8'h6A; 8'h42: lower = 8'h6B; 8'h4B: lower = 8'h6C;
      8'h3A: lower = 8'h6D; 8'h31: lower = 8'h6E; 8'h44: lower = 8'h6F; 8'h4D: lower = 8'h70;
      8'h15: lower = 8'h71; 8'h2D: lower = 8'h72; 8'h1B: lower = 8'h73; 8'h2C: lower = 8'h74;
      8'h3C: lower = 8'h75; 8'h2A: lower = 8'h76; 8'h1D: lower = 8'h77; 8'h22: lower = 8'h78;
      8'h35: lower = 8'h79; 8'h1A: lower = 8'h7A;
      8'h45: lower = 8'h30; 8'h16: lower = 8'h31; 8'h1E: lower = 8'h32; 8'h26: lower = 8'h33;
      8'h25: lower = 8'h34; 8'h2E: lower = 8'h35; 8'h36: lower = 8'h36; 8'h3D: lower = 8'h37;
      8'h3E: lower = 8'h38; 8'h46: lower = 8'h39;
      8'h29: lower = 8'h20;
      default: printable = 1'b0;
    endcase
  end

`ifdef KBD_SHIFT_EN
  always_comb begin
    ascii = lower;
    if (shift) begin
      if (lower >= 8'h61 && lower <= 8'h7A) begin
        ascii = lower - 8'h20;
      end else begin
        case (lower)
          8'h30: ascii = 8'h29; 8'h31: ascii = 8'h21; 8'h32: ascii = 8'h40; 8'h33: ascii = 8'h23;
          8'h34: ascii = 8'h24; 8'h35: ascii = 8'h25; 8'h36: ascii = 8'h5E; 8'h37: ascii = 8'h26;
          8'h38: ascii = 8'h2A; 8'h39: ascii = 8'h28;
          default: ascii = lower;
        endcase
      end
    end
  end
`else
  logic unused_shift;
  assign unused_shift = shift;
  assign ascii        = lower;
`endif

endmodule

// File: rtl/vga_text_writer.sv
// Keyboard-to-vmem writer: decodes PS/2 set-2 bytes, moves the cursor and clears lines.
// Optional shift support is enabled by defining KBD_SHIFT_EN.
module vga_text_writer
  import vga_text_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  kbd_data,
  input  logic        kbd_valid,
  output logic        kbd_ready,
  output logic        vmem_we,
  output logic [11:0] vmem_waddr,
  output logic [7:0]  vmem_wdata,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row
);

  localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW  = 5'(ROWS - 1);
  localparam logic [11:0] INIT_END  = 12'(VMEM_DEPTH);
  localparam logic [11:0] CLEAR_END = 12'(COLS);

  state_t      state_reg, state_next;
  logic [11:0] cnt_reg, cnt_next;
  logic [6:0]  col_reg, col_next;
  logic [4:0]  row_reg, row_next, row_inc;
  logic        brk_reg, brk_next, ext_reg, ext_next;
  logic        we_reg, we_next, ready_reg, ready_next;
  logic [11:0] waddr_reg, waddr_next;
  logic [7:0]  wdata_reg, wdata_next;
  logic [7:0]  ascii;
  logic        printable, shift;

`ifdef KBD_SHIFT_EN
  logic lshift_reg, lshift_next, rshift_reg, rshift_next;
  assign shift = lshift_reg | rshift_reg;
`else
  assign shift = 1'b0;
`endif

  scancode_to_ascii u_lookup (
    .scancode  (kbd_data),
    .shift     (shift),
    .ascii     (ascii),
    .printable (printable)
  );

  assign row_inc = (row_reg == LAST_ROW) ? 5'd0 : row_reg + 5'd1;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    brk_next   = brk_reg;
    ext_next   = ext_reg;
`ifdef KBD_SHIFT_EN
    lshift_next = lshift_reg;
    rshift_next = rshift_reg;
`endif
    we_next    = 1'b0;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    ready_next = 1'b0;
    case (state_reg)
      INIT: begin
        if (cnt_reg == INIT_END) begin
          state_next = IDLE;
          ready_next = 1'b1;
          cnt_next   = 12'd0;
        end else begin
          we_next    = 1'b1;
          waddr_next = cnt_reg;
          wdata_next = ASCII_SPACE;
          cnt_next   = cnt_reg + 12'd1;
        end
      end
      // Counter holds the next column to blank; one idle cycle follows the last write.
      CLEAR: begin
        if (cnt_reg == CLEAR_END) begin
          state_next = IDLE;
          ready_next = 1'b1;
        end else begin
          we_next    = 1'b1;
          waddr_next = {cnt_reg[6:0], row_reg};
          wdata_next = ASCII_SPACE;
          cnt_next   = cnt_reg + 12'd1;
        end
      end
      IDLE: begin
        ready_next = 1'b1;
        if (kbd_valid && ready_reg) begin
          if (kbd_data == SC_BREAK) begin
            brk_next = 1'b1;
          end else if (kbd_data == SC_EXT) begin
            ext_next = 1'b1;
          end else if (brk_reg) begin
            brk_next = 1'b0;
            ext_next = 1'b0;
`ifdef KBD_SHIFT_EN
            if (kbd_data == SC_LSHIFT) lshift_next = 1'b0;
            if (kbd_data == SC_RSHIFT) rshift_next = 1'b0;
`endif
          end else if (ext_reg) begin
            ext_next = 1'b0;
`ifdef KBD_SHIFT_EN
          end else if (kbd_data == SC_LSHIFT) begin
            lshift_next = 1'b1;
          end else if (kbd_data == SC_RSHIFT) begin
            rshift_next = 1'b1;
`endif
          end else if (kbd_data == SC_ENTER) begin
            // Column 0 of the new row is blanked in the same cycle as the accept.
            col_next   = 7'd0;
            row_next   = row_inc;
            we_next    = 1'b1;
            waddr_next = {7'd0, row_inc};
            wdata_next = ASCII_SPACE;
            cnt_next   = 12'd1;
            state_next = CLEAR;
            ready_next = 1'b0;
          end else if (kbd_data == SC_BKSP) begin
            if (col_reg != 7'd0) begin
              col_next   = col_reg - 7'd1;
              we_next    = 1'b1;
              waddr_next = {col_reg - 7'd1, row_reg};
              wdata_next = ASCII_SPACE;
            end else if (row_reg != 5'd0) begin
              col_next   = LAST_COL;
              row_next   = row_reg - 5'd1;
              we_next    = 1'b1;
              waddr_next = {LAST_COL, row_reg - 5'd1};
              wdata_next = ASCII_SPACE;
            end
          end else if (printable) begin
            we_next    = 1'b1;
            waddr_next = {col_reg, row_reg};
            wdata_next = ascii;
            if (col_reg == LAST_COL) begin
              col_next   = 7'd0;
              row_next   = row_inc;
              cnt_next   = 12'd0;
              state_next = CLEAR;
              ready_next = 1'b0;
            end else begin
              col_next = col_reg + 7'd1;
            end
          end
        end
      end
      default: state_next = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= INIT;
      cnt_reg   <= 12'd0;
      col_reg   <= 7'd0;
      row_reg   <= 5'd0;
      brk_reg   <= 1'b0;
      ext_reg   <= 1'b0;
`ifdef KBD_SHIFT_EN
      lshift_reg <= 1'b0;
      rshift_reg <= 1'b0;
`endif
      we_reg    <= 1'b0;
      waddr_reg <= 12'd0;
      wdata_reg <= ASCII_SPACE;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      col_reg   <= col_next;
      row_reg   <= row_next;
      brk_reg   <= brk_next;
      ext_reg   <= ext_next;
`ifdef KBD_SHIFT_EN
      lshift_reg <= lshift_next;
      rshift_reg <= rshift_next;
`endif
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      ready_reg <= ready_next;
    end
  end

  assign kbd_ready  = ready_reg;
  assign vmem_we    = we_reg;
  assign vmem_waddr = waddr_reg;
  assign vmem_wdata = wdata_reg;
  assign cursor_col = col_reg;
  assign cursor_row = row_reg;

endmodule

// File: tb/tb_vga_text_writer.sv
// Scoreboard bench for vga_text_writer: a cursor/flag model queues expected vmem writes,
// a monitor pops them on every vmem_we. Honors KBD_SHIFT_EN like the design.
module tb_vga_text_writer;

`ifdef KBD_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  kbd_data = 8'h00;
  logic        kbd_valid = 1'b0;
  logic        kbd_ready, vmem_we;
  logic [11:0] vmem_waddr;
  logic [7:0]  vmem_wdata;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;

  int total = 0;
  int bad = 0;

  logic [19:0] exp_q[$];
  logic [7:0]  lc_tab[256];
  logic [7:0]  uc_tab[256];
  bit          pr_tab[256];
  logic [7:0]  prn[$];
  int m_col, m_row;
  bit m_brk, m_ext, m_ls, m_rs;

  vga_text_writer dut (
    .clk        (clk),
    .rst        (rst),
    .kbd_data   (kbd_data),
    .kbd_valid  (kbd_valid),
    .kbd_ready  (kbd_ready),
    .vmem_we    (vmem_we),
    .vmem_waddr (vmem_waddr),
    .vmem_wdata (vmem_wdata),
    .cursor_col (cursor_col),
    .cursor_row (cursor_row)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write the DUT presents must be the next expected one.
  always @(negedge clk) begin
    if (vmem_we === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL vmem_write unexpected act addr=%0d data=%0h exp none", vmem_waddr, vmem_wdata);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({vmem_waddr, vmem_wdata} !== e) begin
          bad++;
          $display("FAIL vmem_write act addr=%0d data=%0h exp addr=%0d data=%0h",
                   vmem_waddr, vmem_wdata, e[19:8], e[7:0]);
        end
      end
    end
  end

  function automatic void push_wr(input int col, input int row, input logic [7:0] d);
    exp_q.push_back({12'(col * 32 + row), d});
  endfunction

  function automatic void push_clear_row(input int row);
    for (int c = 0; c < 70; c++) push_wr(c, row, 8'h20);
  endfunction

  // Applies one accepted byte; returns the number of cycles kbd_ready should stay low.
  function automatic int model_byte(input logic [7:0] b);
    int low = 0;
    if (b == 8'hF0) m_brk = 1;
    else if (b == 8'hE0) m_ext = 1;
    else if (m_brk) begin
      m_brk = 0;
      m_ext = 0;
      if (SHIFT_EN && b == 8'h12) m_ls = 0;
      if (SHIFT_EN && b == 8'h59) m_rs = 0;
    end else if (m_ext) m_ext = 0;
    else if (SHIFT_EN && b == 8'h12) m_ls = 1;
    else if (SHIFT_EN && b == 8'h59) m_rs = 1;
    else if (b == 8'h5A) begin
      m_row = (m_row + 1) % 30;
      m_col = 0;
      push_clear_row(m_row);
      low = 70;
    end else if (b == 8'h66) begin
      if (m_col > 0) begin
        m_col--;
        push_wr(m_col, m_row, 8'h20);
      end else if (m_row > 0) begin
        m_row--;
        m_col = 69;
        push_wr(m_col, m_row, 8'h20);
      end
    end else if (pr_tab[b]) begin
      push_wr(m_col, m_row, (SHIFT_EN && (m_ls || m_rs)) ? uc_tab[b] : lc_tab[b]);
      if (m_col == 69) begin
        m_col = 0;
        m_row = (m_row + 1) % 30;
        push_clear_row(m_row);
        low = 71;
      end else m_col++;
    end
    return low;
  endfunction

  task automatic send(input logic [7:0] b, input bit wait_ready);
    int guard, low, exp_low;
    @(negedge clk);
    kbd_data  = b;
    kbd_valid = 1'b1;
    guard = 0;
    while (!kbd_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!kbd_ready) begin
      chk("send_timeout", 0, 1);
      kbd_valid = 1'b0;
      return;
    end
    exp_low = model_byte(b);
    @(negedge clk);
    kbd_valid = 1'b0;
    chk("cursor_col", cursor_col, m_col);
    chk("cursor_row", cursor_row, m_row);
    if (wait_ready) begin
      low = 0;
      while (!kbd_ready && low < 200) begin
        @(negedge clk);
        low++;
      end
      chk("ready_low_cycles", low, exp_low);
    end
  endtask

  task automatic do_reset;
    int cyc;
    @(negedge clk);
    rst = 1'b1;
    kbd_valid = 1'b0;
    @(negedge clk);
    chk("rst_we", vmem_we, 0);
    chk("rst_ready", kbd_ready, 0);
    chk("rst_waddr", vmem_waddr, 0);
    chk("rst_wdata", vmem_wdata, 8'h20);
    chk("rst_col", cursor_col, 0);
    chk("rst_row", cursor_row, 0);
    exp_q.delete();
    m_col = 0; m_row = 0; m_brk = 0; m_ext = 0; m_ls = 0; m_rs = 0;
    for (int i = 0; i < 2240; i++) exp_q.push_back({12'(i), 8'h20});
    rst = 1'b0;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!kbd_ready && cyc < 3000);
    chk("init_cycles_to_ready", cyc, 2241);
    chk("init_writes_left", exp_q.size(), 0);
    chk("init_col", cursor_col, 0);
    chk("init_row", cursor_row, 0);
  endtask

  initial begin
    logic [7:0] letter_sc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                  8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                  8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] digit_sc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] unmapped[3] = '{8'h05, 8'h76, 8'h0D};
    string sym = ")!@#$%^&*(";
    int guard;

    for (int i = 0; i < 256; i++) begin
      lc_tab[i] = 8'h00; uc_tab[i] = 8'h00; pr_tab[i] = 1'b0;
    end
    for (int i = 0; i < 26; i++) begin
      pr_tab[letter_sc[i]] = 1'b1;
      lc_tab[letter_sc[i]] = 8'h61 + 8'(i);
      uc_tab[letter_sc[i]] = 8'h41 + 8'(i);
      prn.push_back(letter_sc[i]);
    end
    for (int i = 0; i < 10; i++) begin
      pr_tab[digit_sc[i]] = 1'b1;
      lc_tab[digit_sc[i]] = 8'h30 + 8'(i);
      uc_tab[digit_sc[i]] = sym[i];
      prn.push_back(digit_sc[i]);
    end
    pr_tab[8'h29] = 1'b1; lc_tab[8'h29] = 8'h20; uc_tab[8'h29] = 8'h20;
    prn.push_back(8'h29);

    do_reset();

    // Directed: backspace at origin, make/break, shift, Enter, backspace across rows.
    send(8'h66, 1);
    send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 1);
    send(8'h12, 1); send(8'h1C, 1); send(8'hF0, 1); send(8'h12, 1); send(8'h1C, 1);
    send(8'h1C, 1); send(8'h1C, 1);
    send(8'h5A, 1);
    send(8'h5A, 1);
    send(8'h66, 1);

    // Walk to row 29, fill it, and wrap on the last column.
    for (int i = 0; i < 28; i++) send(8'h5A, 1);
    for (int i = 0; i < 69; i++) send(prn[$urandom_range(prn.size() - 1)], 1);
    send(8'h16, 1);

    // Random traffic, sometimes offering the next byte while the writer is busy.
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(99);
      if (r < 65) b = prn[$urandom_range(prn.size() - 1)];
      else if (r < 73) b = 8'hF0;
      else if (r < 76) b = 8'hE0;
      else if (r < 81) b = r[0] ? 8'h12 : 8'h59;
      else if (r < 85) b = 8'h5A;
      else if (r < 92) b = 8'h66;
      else b = unmapped[$urandom_range(2)];
      send(b, $urandom_range(7) != 0);
    end

    // Reset in the middle of a line clear restarts INIT from scratch.
    send(8'h5A, 0);
    repeat (10) @(negedge clk);
    do_reset();
    send(8'h24, 1);

    guard = 0;
    while ((!kbd_ready || exp_q.size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    chk("final_writes_left", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
